// File: rtl/password_fsm.sv
// password_fsm
//   Password-entry controller for the gated memory path. Shifts in DIGITS
//   keypad digits, compares them against PASSWORD, then either opens an
//   access window (GRANT) or counts a failure. After MAX_TRIES consecutive
//   failures it enters a timed lockout (LOCK). Both windows are timed in
//   tick_in pulses.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   tick_in         : one-cycle timebase pulse
//   digit_valid     : one-cycle strobe, digit holds a keypress
//   digit           : keypad digit value
//   clear           : abort entry / log out of GRANT
//   access_granted  : high for the whole GRANT state
//   locked          : high for the whole LOCK state
//   fail_pulse      : one-cycle pulse per wrong code
//   entry_count     : digits accepted in the current entry
//   tries_left      : remaining attempts before lockout
// All outputs come straight from flops.
module password_fsm #(
   parameter int                      DIGITS      = 4,
   parameter int                      DIGIT_W     = 4,
   parameter logic [DIGITS*DIGIT_W-1:0] PASSWORD  = 16'h1947,
   parameter int                      MAX_TRIES   = 3,
   parameter int                      GRANT_TICKS = 4,
   parameter int                      LOCK_TICKS  = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               tick_in,
   input  logic                               digit_valid,
   input  logic [DIGIT_W-1:0]                 digit,
   input  logic                               clear,
   output logic                               access_granted,
   output logic                               locked,
   output logic                               fail_pulse,
   output logic [$clog2(DIGITS+1)-1:0]        entry_count,
   output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

   localparam int CODE_W  = DIGITS * DIGIT_W;
   localparam int CNT_W   = $clog2(DIGITS + 1);
   localparam int TRY_W   = $clog2(MAX_TRIES + 1);
   localparam int MAX_TK  = (GRANT_TICKS > LOCK_TICKS) ? GRANT_TICKS : LOCK_TICKS;
   localparam int TICK_W  = $clog2(MAX_TK + 1);

   typedef enum logic [1:0] {
      S_ENTRY = 2'd0,
      S_CHECK = 2'd1,
      S_GRANT = 2'd2,
      S_LOCK  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    entry_count_q, entry_count_d;
   logic [TRY_W-1:0]    tries_left_q, tries_left_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic                access_granted_q, access_granted_d;
   logic                locked_q, locked_d;
   logic                fail_pulse_q, fail_pulse_d;

   always_comb begin
      state_d          = state_q;
      shift_d          = shift_q;
      entry_count_d    = entry_count_q;
      tries_left_d     = tries_left_q;
      tick_cnt_d       = tick_cnt_q;
      fail_pulse_d     = 1'b0;

      unique case (state_q)
         S_ENTRY: begin
            if (clear) begin
               entry_count_d = '0;
               shift_d       = '0;
            end else if (digit_valid) begin
               // first digit ends up in the MSBs after DIGITS shifts
               shift_d       = (shift_q << DIGIT_W) | CODE_W'(digit);
               entry_count_d = entry_count_q + CNT_W'(1);
               if (entry_count_q == CNT_W'(DIGITS - 1))
                  state_d = S_CHECK;
            end
         end

         S_CHECK: begin
            entry_count_d = '0;
            tick_cnt_d    = '0;
            if (shift_q == PASSWORD) begin
               state_d      = S_GRANT;
               tries_left_d = TRY_W'(MAX_TRIES);
            end else begin
               fail_pulse_d = 1'b1;
               tries_left_d = tries_left_q - TRY_W'(1);
               state_d      = (tries_left_q == TRY_W'(1)) ? S_LOCK : S_ENTRY;
            end
         end

         S_GRANT: begin
            // logout wins over a coincident tick
            if (clear) begin
               state_d = S_ENTRY;
            end else if (tick_in) begin
               if (tick_cnt_q == TICK_W'(GRANT_TICKS - 1))
                  state_d = S_ENTRY;
               else
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
         end

         S_LOCK: begin
            if (tick_in) begin
               if (tick_cnt_q == TICK_W'(LOCK_TICKS - 1)) begin
                  state_d      = S_ENTRY;
                  tries_left_d = TRY_W'(MAX_TRIES);
               end else begin
                  tick_cnt_d = tick_cnt_q + TICK_W'(1);
               end
            end
         end

         default: state_d = S_ENTRY;
      endcase

      // leaving CHECK starts a fresh entry
      if (state_q == S_CHECK)
         shift_d = '0;

      access_granted_d = (state_d == S_GRANT);
      locked_d         = (state_d == S_LOCK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_ENTRY;
         shift_q          <= '0;
         entry_count_q    <= '0;
         tries_left_q     <= TRY_W'(MAX_TRIES);
         tick_cnt_q       <= '0;
         access_granted_q <= 1'b0;
         locked_q         <= 1'b0;
         fail_pulse_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         shift_q          <= shift_d;
         entry_count_q    <= entry_count_d;
         tries_left_q     <= tries_left_d;
         tick_cnt_q       <= tick_cnt_d;
         access_granted_q <= access_granted_d;
         locked_q         <= locked_d;
         fail_pulse_q     <= fail_pulse_d;
      end
   end

   assign access_granted = access_granted_q;
   assign locked         = locked_q;
   assign fail_pulse     = fail_pulse_q;
   assign entry_count    = entry_count_q;
   assign tries_left     = tries_left_q;

endmodule

// File: tb/tb_password_fsm.sv
// Directed bench for password_fsm. Observed outputs are packed as
// {access_granted, locked, fail_pulse, entry_count[2:0], tries_left[1:0]}.
module tb_password_fsm;

   logic       clk = 1'b0;
   logic       rst, tick_in, digit_valid, clear;
   logic [3:0] digit;
   logic       access_granted, locked, fail_pulse;
   logic [2:0] entry_count;
   logic [1:0] tries_left;

   int   vecs = 0;
   int   errs = 0;
   logic [7:0] obs, exp;

   always #5 clk = ~clk;

   assign obs = {access_granted, locked, fail_pulse, entry_count, tries_left};

   password_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .tick_in       (tick_in),
      .digit_valid   (digit_valid),
      .digit         (digit),
      .clear         (clear),
      .access_granted(access_granted),
      .locked        (locked),
      .fail_pulse    (fail_pulse),
      .entry_count   (entry_count),
      .tries_left    (tries_left)
   );

   // advance one clock; outputs are then stable for sampling
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      digit_valid = 1'b1;
      digit       = d;
      cyc();
      digit_valid = 1'b0;
   endtask

   // leaves the DUT in CHECK right after the last digit edge
   task automatic enter(input logic [15:0] code);
      press(code[15:12]);
      press(code[11:8]);
      press(code[7:4]);
      press(code[3:0]);
   endtask

   task automatic tick();
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL reset: got %b want %b", obs, exp); end
   endtask

   task automatic test_grant();
      press(4'h1);
      press(4'h9);
      exp = {1'b0, 1'b0, 1'b0, 3'd2, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_partial: got %b want %b", obs, exp); end
      press(4'h4);
      press(4'h7);
      exp = {1'b0, 1'b0, 1'b0, 3'd4, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_check: got %b want %b", obs, exp); end
      cyc();
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_open: got %b want %b", obs, exp); end
      tick(); tick(); tick();
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_3ticks: got %b want %b", obs, exp); end
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_expire: got %b want %b", obs, exp); end
   endtask

   task automatic test_wrong_then_right();
      enter(16'h1234);
      cyc();
      exp = {1'b0, 1'b0, 1'b1, 3'd0, 2'd2};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL wrong_pulse: got %b want %b", obs, exp); end
      cyc();
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd2};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL wrong_pulse_end: got %b want %b", obs, exp); end
      enter(16'h1947);
      cyc();
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL retry_grant: got %b want %b", obs, exp); end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL logout: got %b want %b", obs, exp); end
   endtask

   task automatic test_lockout();
      enter(16'h1234);
      cyc();
      cyc();
      // digit order matters: reversed code must be rejected
      enter(16'h7491);
      cyc();
      exp = {1'b0, 1'b0, 1'b1, 3'd0, 2'd1};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL reversed_code: got %b want %b", obs, exp); end
      cyc();
      enter(16'h0000);
      cyc();
      exp = {1'b0, 1'b1, 1'b1, 3'd0, 2'd0};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL lock_enter: got %b want %b", obs, exp); end
      enter(16'h1947);
      cyc();
      exp = {1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL lock_ignore_digits: got %b want %b", obs, exp); end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL lock_ignore_clear: got %b want %b", obs, exp); end
      for (int i = 0; i < 7; i++) tick();
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL lock_7ticks: got %b want %b", obs, exp); end
      tick_in = 1'b1;
      cyc();
      tick_in = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL lock_expire: got %b want %b", obs, exp); end
   endtask

   task automatic test_clear_entry();
      press(4'h1);
      press(4'h9);
      exp = {1'b0, 1'b0, 1'b0, 3'd2, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL clear_pre: got %b want %b", obs, exp); end
      // clear beats a simultaneous digit strobe
      clear       = 1'b1;
      digit_valid = 1'b1;
      digit       = 4'h4;
      cyc();
      clear       = 1'b0;
      digit_valid = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL clear_entry: got %b want %b", obs, exp); end
      enter(16'h1947);
      exp = {1'b0, 1'b0, 1'b0, 3'd4, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL clear_reentry: got %b want %b", obs, exp); end
      cyc();
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL clear_grant: got %b want %b", obs, exp); end
   endtask

   task automatic test_grant_clear_tick();
      // still in GRANT from previous test; one counted tick first
      tick();
      press(4'h5);
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_ignore_digit: got %b want %b", obs, exp); end
      clear   = 1'b1;
      tick_in = 1'b1;
      cyc();
      clear   = 1'b0;
      tick_in = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_clear_tick: got %b want %b", obs, exp); end
      // fresh grant must get the full GRANT_TICKS window again
      enter(16'h1947);
      cyc();
      tick(); tick(); tick();
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL grant_counter_restart: got %b want %b", obs, exp); end
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic test_reset_midway();
      enter(16'h1111);
      cyc();
      cyc();
      enter(16'h2222);
      cyc();
      cyc();
      enter(16'h3333);
      cyc();
      tick();
      exp = {1'b0, 1'b1, 1'b0, 3'd0, 2'd0};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL mid_lock: got %b want %b", obs, exp); end
      do_reset();
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_in_lock: got %b want %b", obs, exp); end
      enter(16'h4444);
      cyc();
      cyc();
      press(4'h1);
      press(4'h9);
      exp = {1'b0, 1'b0, 1'b0, 3'd2, 2'd2};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL mid_entry: got %b want %b", obs, exp); end
      do_reset();
      exp = {1'b0, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_in_entry: got %b want %b", obs, exp); end
      // shift register must be clean after reset: a full correct code grants
      enter(16'h1947);
      cyc();
      exp = {1'b1, 1'b0, 1'b0, 3'd0, 2'd3};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL post_rst_grant: got %b want %b", obs, exp); end
   endtask

   initial begin
      rst         = 1'b1;
      tick_in     = 1'b0;
      digit_valid = 1'b0;
      clear       = 1'b0;
      digit       = 4'h0;
      #2;
      test_reset();
      test_grant();
      test_wrong_then_right();
      test_lockout();
      test_clear_entry();
      test_grant_clear_tick();
      test_reset_midway();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
